// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and default widths for the two-port memory bus arbiter.
package mem_bus_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: zero latency, purely combinational.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = req0 | req1;
        grant       = 1'b0;
        if (req0 && req1) begin
            grant = ~last_grant;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between two masters; done arrives WAIT_STATES+2 cycles after request.
// Requests are held by the masters until done; a losing or late request simply waits in IDLE.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_read,
    input  logic              m0_write,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_done,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_read,
    input  logic              m1_write,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              grant,
    output logic              busy
);

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    state_t            state, state_n;
    op_t               op, op_n;
    logic [3:0]        cnt, cnt_n;
    logic              last_grant, last_grant_n;
    logic              grant_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [DATA_W-1:0] rdata0_n, rdata1_n;
    logic              oe_n, we_n, done0_n, done1_n;
    logic              arb_vld, arb_gnt;

    rr_arb2 u_arb (
        .req0        (m0_read | m0_write),
        .req1        (m1_read | m1_write),
        .last_grant  (last_grant),
        .grant_valid (arb_vld),
        .grant       (arb_gnt)
    );

    assign busy = (state == S_ACCESS) || (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            op         <= OP_READ;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            mem_oe     <= 1'b0;
            mem_we     <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
        end else begin
            state      <= state_n;
            op         <= op_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            grant      <= grant_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            m0_rdata   <= rdata0_n;
            m1_rdata   <= rdata1_n;
            mem_oe     <= oe_n;
            mem_we     <= we_n;
            m0_done    <= done0_n;
            m1_done    <= done1_n;
        end
    end

    always_comb begin
        state_n      = state;
        op_n         = op;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        grant_n      = grant;
        addr_n       = mem_addr;
        wdata_n      = mem_wdata;
        rdata0_n     = m0_rdata;
        rdata1_n     = m1_rdata;
        oe_n         = mem_oe;
        we_n         = mem_we;
        done0_n      = 1'b0;
        done1_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (arb_vld) begin
                    grant_n = arb_gnt;
                    addr_n  = arb_gnt ? m1_addr  : m0_addr;
                    wdata_n = arb_gnt ? m1_wdata : m0_wdata;
                    // write wins when a master raises both read and write
                    op_n    = (arb_gnt ? m1_write : m0_write) ? OP_WRITE : OP_READ;
                    oe_n    = (op_n == OP_READ);
                    we_n    = (op_n == OP_WRITE);
                    cnt_n   = WS_INIT;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else begin
                    if (op == OP_READ) begin
                        if (grant) rdata1_n = mem_rdata;
                        else       rdata0_n = mem_rdata;
                    end
                    oe_n    = 1'b0;
                    we_n    = 1'b0;
                    done0_n = ~grant;
                    done1_n = grant;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                last_grant_n = grant;
                state_n      = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: three arbiters (WAIT_STATES 0, 2, 3), each with its own async-read memory.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset    [3];
    logic [15:0] m0_addr  [3];
    logic [15:0] m1_addr  [3];
    logic [7:0]  m0_wdata [3];
    logic [7:0]  m1_wdata [3];
    logic        m0_read  [3];
    logic        m0_write [3];
    logic        m1_read  [3];
    logic        m1_write [3];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic [15:0] mem_addr;
        logic [7:0]  mem_wdata, mem_rdata, m0_rdata, m1_rdata;
        logic        m0_done, m1_done, mem_oe, mem_we, grant, busy;
        logic [7:0]  mem [1024];

        initial begin
            for (int a = 0; a < 1024; a++) mem[a] = 8'(a + 8);
            mem[8] = 8'h80;
        end
        always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        assign mem_rdata = mem[mem_addr[9:0]];

        mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_STATES(WS)) u_dut (
            .clk(clk), .reset(reset[g]),
            .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]), .m0_read(m0_read[g]),
            .m0_write(m0_write[g]), .m0_rdata(m0_rdata), .m0_done(m0_done),
            .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]), .m1_read(m1_read[g]),
            .m1_write(m1_write[g]), .m1_rdata(m1_rdata), .m1_done(m1_done),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
            .mem_oe(mem_oe), .mem_we(mem_we), .grant(grant), .busy(busy)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1;
            m0_addr[i] = '0; m1_addr[i] = '0; m0_wdata[i] = '0; m1_wdata[i] = '0;
            m0_read[i] = 1'b0; m0_write[i] = 1'b0; m1_read[i] = 1'b0; m1_write[i] = 1'b0;
        end
        tick(); tick();

        chk("rst_mem_addr",  g_dut[0].mem_addr,  16'h0);
        chk("rst_mem_wdata", g_dut[0].mem_wdata, 8'h0);
        chk("rst_m0_rdata",  g_dut[0].m0_rdata,  8'h0);
        chk("rst_m1_rdata",  g_dut[0].m1_rdata,  8'h0);
        chk("rst_m0_done",   g_dut[0].m0_done,   1'b0);
        chk("rst_m1_done",   g_dut[0].m1_done,   1'b0);
        chk("rst_mem_oe",    g_dut[0].mem_oe,    1'b0);
        chk("rst_mem_we",    g_dut[0].mem_we,    1'b0);
        chk("rst_grant",     g_dut[0].grant,     1'b0);
        chk("rst_busy",      g_dut[0].busy,      1'b0);
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;
        tick();
        chk("idle_oe", g_dut[0].mem_oe, 1'b0);

        // Single read on port 0, no wait states
        m0_addr[0] = 16'h0008; m0_read[0] = 1'b1;
        tick();
        chk("rd_oe_t1",   g_dut[0].mem_oe,   1'b1);
        chk("rd_busy_t1", g_dut[0].busy,     1'b1);
        chk("rd_done_t1", g_dut[0].m0_done,  1'b0);
        chk("rd_addr_t1", g_dut[0].mem_addr, 16'h0008);
        tick();
        chk("rd_done_t2",  g_dut[0].m0_done,  1'b1);
        chk("rd_rdata_t2", g_dut[0].m0_rdata, 8'h80);
        chk("rd_m1done",   g_dut[0].m1_done,  1'b0);
        chk("rd_oe_t2",    g_dut[0].mem_oe,   1'b0);
        m0_read[0] = 1'b0;
        tick();
        chk("rd_done_t3", g_dut[0].m0_done, 1'b0);
        chk("rd_busy_t3", g_dut[0].busy,    1'b0);

        // Read and write together on port 0: must behave as a write
        m0_addr[0] = 16'h0010; m0_wdata[0] = 8'h3C; m0_read[0] = 1'b1; m0_write[0] = 1'b1;
        tick();
        chk("rw_we_t1", g_dut[0].mem_we, 1'b1);
        chk("rw_oe_t1", g_dut[0].mem_oe, 1'b0);
        tick();
        chk("rw_done_t2", g_dut[0].m0_done, 1'b1);
        chk("rw_oe_t2",   g_dut[0].mem_oe,  1'b0);
        chk("rw_we_t2",   g_dut[0].mem_we,  1'b0);
        chk("rw_rdata",   g_dut[0].m0_rdata, 8'h80);
        m0_read[0] = 1'b0; m0_write[0] = 1'b0;
        chk("rw_mem", g_dut[0].mem[16], 8'h3C);
        tick();

        // Reset clears rdata and restores last_grant; then held ties alternate 0,1,0,1
        reset[0] = 1'b1;
        tick();
        reset[0] = 1'b0;
        chk("rst2_rdata0", g_dut[0].m0_rdata, 8'h0);
        m0_addr[0] = 16'h0000; m0_read[0] = 1'b1;
        m1_addr[0] = 16'h0001; m1_read[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("tie_grant", g_dut[0].grant, 32'(k % 2));
            tick();
            chk("tie_m0done", g_dut[0].m0_done, 32'((k % 2) == 0));
            chk("tie_m1done", g_dut[0].m1_done, 32'((k % 2) == 1));
            if (k == 3) begin
                m0_read[0] = 1'b0; m1_read[0] = 1'b0;
            end
            tick();
            chk("tie_idle", g_dut[0].busy, 1'b0);
        end
        chk("tie_rdata0", g_dut[0].m0_rdata, 8'h08);
        chk("tie_rdata1", g_dut[0].m1_rdata, 8'h09);

        // Port 1 write then readback, WAIT_STATES=2; address change after grant ignored
        m1_addr[1] = 16'h0100; m1_wdata[1] = 8'hA5; m1_write[1] = 1'b1;
        tick();
        chk("wr_we_t1",    g_dut[1].mem_we, 1'b1);
        chk("wr_grant_t1", g_dut[1].grant,  1'b1);
        m1_addr[1] = 16'h0200; m1_wdata[1] = 8'h11;
        tick();
        chk("wr_we_t2",   g_dut[1].mem_we,   1'b1);
        chk("wr_latched", g_dut[1].mem_addr, 16'h0100);
        tick();
        chk("wr_we_t3",   g_dut[1].mem_we,  1'b1);
        chk("wr_done_t3", g_dut[1].m1_done, 1'b0);
        tick();
        chk("wr_we_t4",   g_dut[1].mem_we,  1'b0);
        chk("wr_done_t4", g_dut[1].m1_done, 1'b1);
        chk("wr_m0done",  g_dut[1].m0_done, 1'b0);
        m1_write[1] = 1'b0;
        tick();
        chk("wr_mem200", g_dut[1].mem[10'h200], 8'h08);
        m1_addr[1] = 16'h0100; m1_read[1] = 1'b1;
        tick(); tick(); tick();
        chk("rb_done_t3", g_dut[1].m1_done, 1'b0);
        tick();
        chk("rb_done_t4", g_dut[1].m1_done,  1'b1);
        chk("rb_rdata",   g_dut[1].m1_rdata, 8'hA5);
        m1_read[1] = 1'b0;
        tick();

        // Port 1 arrives during port 0's ACCESS and is served next
        m0_addr[1] = 16'h0020; m0_read[1] = 1'b1;
        tick();
        chk("mid_grant0", g_dut[1].grant, 1'b0);
        m1_addr[1] = 16'h0021; m1_read[1] = 1'b1;
        tick(); tick(); tick();
        chk("mid_m0done", g_dut[1].m0_done,  1'b1);
        chk("mid_rdata0", g_dut[1].m0_rdata, 8'h28);
        chk("mid_m1wait", g_dut[1].m1_done,  1'b0);
        m0_read[1] = 1'b0;
        tick();
        chk("mid_idle", g_dut[1].busy, 1'b0);
        tick();
        chk("mid_grant1", g_dut[1].grant, 1'b1);
        tick(); tick(); tick();
        chk("mid_m1done", g_dut[1].m1_done,  1'b1);
        chk("mid_rdata1", g_dut[1].m1_rdata, 8'h29);
        chk("mid_rdata0_hold", g_dut[1].m0_rdata, 8'h28);
        m1_read[1] = 1'b0;
        tick();

        // Reset during the 2nd ACCESS cycle of a write, WAIT_STATES=3
        m1_addr[2] = 16'h0005; m1_read[2] = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("pre_m1done", g_dut[2].m1_done,  1'b1);
        chk("pre_rdata1", g_dut[2].m1_rdata, 8'h0D);
        m1_read[2] = 1'b0;
        tick();
        m0_addr[2] = 16'h0030; m0_wdata[2] = 8'h77; m0_write[2] = 1'b1;
        tick();
        chk("ab_we_t1", g_dut[2].mem_we, 1'b1);
        tick();
        reset[2] = 1'b1; m0_write[2] = 1'b0;
        tick();
        chk("ab_we",     g_dut[2].mem_we,   1'b0);
        chk("ab_busy",   g_dut[2].busy,     1'b0);
        chk("ab_done",   g_dut[2].m0_done,  1'b0);
        chk("ab_rdata0", g_dut[2].m0_rdata, 8'h0);
        chk("ab_rdata1", g_dut[2].m1_rdata, 8'h0);
        reset[2] = 1'b0;
        tick();
        chk("ab_done_after", g_dut[2].m0_done, 1'b0);
        m0_addr[2] = 16'h0005; m0_read[2] = 1'b1;
        tick(); tick(); tick(); tick();
        chk("fr_done_t4", g_dut[2].m0_done, 1'b0);
        tick();
        chk("fr_done_t5", g_dut[2].m0_done,  1'b1);
        chk("fr_rdata",   g_dut[2].m0_rdata, 8'h0D);
        m0_read[2] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
